merge_switch_rr: RTL

Parametrised N-to-1 merge switch for the accelerator NoC: NUM_IN input channels, each buffered by a FIFO_DEPTH-entry FIFO, are merged onto one registered output channel. A round-robin or fixed-priority arbiter selects the channel, with a per-input mask and full valid/ready backpressure on both sides. It is the buffered, multi-port successor to the 2-input merge switch and sits at reduction points of the distribution/collection trees.

---
 rtl/noc_pkg.sv | 21 ++
 rtl/fifo_sync.sv | 62 ++++++
 rtl/merge_switch_rr.sv | 95 +++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: arbitration mode encodings and a clog2 helper.
package noc_pkg;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } arb_mode_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous pointer-plus-count FIFO with show-ahead head and full/empty flags.
module fifo_sync
    import noc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W = clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array write; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/merge_switch_rr.sv
// N-to-1 buffered merge switch: per-input FIFOs, masked round-robin or
// fixed-priority arbitration, and a registered valid/ready output stage.
module merge_switch_rr
    import noc_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned NUM_IN     = 4,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned IDX_W      = clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN-1:0]            i_valid,
    output logic [NUM_IN-1:0]            o_ready,
    input  logic [NUM_IN*DATA_WIDTH-1:0] i_data_bus,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DATA_WIDTH-1:0]        o_data_bus,
    output logic [IDX_W-1:0]             o_src,
    input  logic                         i_en,
    input  logic                         i_mode,
    input  logic [NUM_IN-1:0]            i_mask
);

    logic [NUM_IN-1:0]     full;
    logic [NUM_IN-1:0]     empty;
    logic [NUM_IN-1:0]     push;
    logic [NUM_IN-1:0]     pop;
    logic [NUM_IN-1:0]     eligible;
    logic [DATA_WIDTH-1:0] heads [NUM_IN];
    logic [2*NUM_IN-1:0]   req_dbl;
    logic [IDX_W-1:0]      last_gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_found;
    logic                  load;
    int unsigned           start;

    assign o_ready  = ~full;
    assign eligible = ~empty & i_mask;
    assign load     = i_en && (!o_valid || i_ready) && gnt_found;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_fifo
        assign push[k] = i_valid[k] && !full[k];
        assign pop[k]  = load && (gnt_idx == IDX_W'(k));

        fifo_sync #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push[k]),
            .push_data(i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
            .pop      (pop[k]),
            .head     (heads[k]),
            .full     (full[k]),
            .empty    (empty[k])
        );
    end

    // Arbiter: the request vector is duplicated and bits below the start index
    // are ignored, so the first hit wraps modulo NUM_IN. Fixed priority starts at 0.
    always_comb begin
        start     = (i_mode == MODE_FIXED) ? 0 : int'(last_gnt) + 1;
        req_dbl   = {eligible, eligible};
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < 2 * NUM_IN; i++) begin
            if (!gnt_found && (i >= start) && req_dbl[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(i % NUM_IN);
            end
        end
    end

    // Output register and round-robin pointer; an unreplaced handshake clears the stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid    <= 1'b0;
            o_data_bus <= '0;
            o_src      <= '0;
            last_gnt   <= IDX_W'(NUM_IN - 1);
        end else if (load) begin
            o_valid    <= 1'b1;
            o_data_bus <= heads[gnt_idx];
            o_src      <= gnt_idx;
            last_gnt   <= gnt_idx;
        end else if (i_ready) begin
            o_valid    <= 1'b0;
            o_data_bus <= '0;
            o_src      <= '0;
        end
    end

endmodule
